// File: rtl/screen_draw_ctrl.sv
// Full-frame pixel scan sequencer: walks (x,y) over the screen, drives the ROM address,
// and emits plot-aligned x/y/black/plot one cycle behind the address (1-cycle ROM latency).
module screen_draw_ctrl #(
  parameter int XMAX   = 160,
  parameter int YMAX   = 120,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              drawReq,
  input  logic              clearReq,
  input  logic [6:0]        drawSel,
  output logic [ADDR_W-1:0] address,
  output logic [6:0]        memorySel,
  output logic              black,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic              plot,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

  localparam logic [7:0] X_LAST = 8'(XMAX - 1);
  localparam logic [6:0] Y_LAST = 7'(YMAX - 1);

  state_t      state_q, state_d;
  logic [7:0]  cx_q, cx_d;
  logic [6:0]  cy_q, cy_d;
  logic [6:0]  msel_q, msel_d;
  logic        black_q, black_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic        plot_q, plot_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      msel_q  <= '0;
      black_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      plot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      msel_q  <= msel_d;
      black_q <= black_d;
      x_q     <= x_d;
      y_q     <= y_d;
      plot_q  <= plot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    msel_d  = msel_q;
    black_d = black_q;
    // Plot stage trails the fetch stage by one cycle to line up with ROM data.
    plot_d  = (state_q == SCAN);
    x_d     = (state_q == SCAN) ? cx_q : x_q;
    y_d     = (state_q == SCAN) ? cy_q : y_q;

    unique case (state_q)
      IDLE: begin
        cx_d = '0;
        cy_d = '0;
        if (clearReq) begin
          black_d = 1'b1;
          state_d = SCAN;
        end else if (drawReq) begin
          msel_d  = drawSel;
          black_d = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (cx_q == X_LAST) begin
          if (cy_q == Y_LAST) begin
            state_d = FLUSH;
          end else begin
            cx_d = '0;
            cy_d = cy_q + 7'd1;
          end
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end
      FLUSH: state_d = DONE;
      DONE: begin
        // Return the counters to the origin so address reads 0 while idle.
        cx_d    = '0;
        cy_d    = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  if (XMAX == 160) begin : g_shift_addr
    assign address = (ADDR_W'(cy_q) << 7) + (ADDR_W'(cy_q) << 5) + ADDR_W'(cx_q);
  end else begin : g_mul_addr
    assign address = ADDR_W'(cy_q) * ADDR_W'(XMAX) + ADDR_W'(cx_q);
  end

  assign memorySel = msel_q;
  assign black     = black_q;
  assign x         = x_q;
  assign y         = y_q;
  assign plot      = plot_q;
  assign busy      = (state_q == SCAN) || (state_q == FLUSH);
  assign done      = (state_q == DONE);

endmodule
